mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Sequences and shares the single-port synchronous memory between two requesters: the multicycle MIPS core (CPU port) and a debug/program-loader port (DBG port).
- Owns all memory control: address, write enable, read-latency wait and response capture.
- Performs one access at a time, round-robin or fixed-priority.
- Sits between mips_control/datapath memory signals and the memory block.

Parameters:
- ADDR_W, 10, word-address width on all ports.
- MEM_WORDS, 1024, number of implemented words; addresses >= MEM_WORDS are out of range.
- READ_LATENCY, 2, cycles from mem_addr presented to mem_rdata valid (>=1).
- CPU_PRIORITY, 0, 0 = round-robin; 1 = CPU always wins a tie.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data, valid while cpu_ack=1
- cpu_err  out  1  out-of-range flag, valid while cpu_ack=1
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata, dbg_err: same as the CPU port, for DBG
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=DBG (CPU wins first tie). All outputs 0: acks, errs, rdata, mem_we, mem_addr, mem_wdata, busy. Reset mid-access aborts immediately and mem_we drops asynchronously; no ack is issued.
- States: IDLE, ACCESS, WAIT, ACK. Counter cnt is wide enough for READ_LATENCY.
- IDLE: req is sampled only here. No req: stay. One req: grant it. Both: CPU_PRIORITY=1 grants CPU; otherwise grant the port not equal to last_grant. On grant, latch owner, we, addr and wdata; update last_grant; go to ACCESS. Changes to inputs after the latch are ignored.
- ACCESS (1 cycle): mem_addr=latched addr. In range, write: mem_we=1 this cycle only, mem_wdata=latched data, go to ACK. In range, read: mem_we=0, cnt=1, go to WAIT. Out of range: mem_we=0, set err, go to ACK with rdata=0.
- WAIT: hold mem_addr, mem_we=0. If cnt==READ_LATENCY, capture mem_rdata into rdata register and go to ACK; else cnt++.
- ACK (1 cycle): owner's ack=1, rdata/err valid, other port's ack=0, then IDLE. rdata holds its value until the next read capture.
- Latency, with req seen in IDLE at cycle t: write ack at t+2; read ack at t+2+READ_LATENCY (t+4 at default); out-of-range ack at t+2.
- Back-to-back: a requester still asserting req in the IDLE cycle after its ack starts a new access. To issue one access, drop req the cycle after the ack.
- Simultaneous requests never both ack. A loser keeps req high and is granted at the next IDLE.
- Under round-robin, a continuously requesting pair alternates CPU, DBG, CPU, ...

Decomposition:
- mips_defines.v gains the ARB_IDLE/ARB_ACCESS/ARB_WAIT/ARB_ACK encodings and the OWNER_CPU/OWNER_DBG constants.
- One sub-module: mips_arb_pick, combinational 2-way pick from (cpu_req, dbg_req, last_grant, CPU_PRIORITY) to a grant select. FSM, latches and counter stay in mips_mem_arbiter.

Test Plan:
- CPU write, addr 0x010, data 0xDEADBEEF, at t -> mem_we=1 only at t+1 with mem_addr=0x010; cpu_ack at t+2; dbg_ack stays 0.
- CPU read of 0x010 (memory model latency 2) -> mem_addr=0x010 over t+1..t+3; cpu_ack at t+4 with cpu_rdata=0xDEADBEEF; cpu_err=0.
- cpu_req and dbg_req both rise at t from reset, both held -> CPU acked first, then DBG, then CPU (alternating). With CPU_PRIORITY=1, CPU every time.
- DBG read at addr 1024 (MEM_WORDS=1024) -> no mem_we; dbg_ack at t+2 with dbg_err=1, dbg_rdata=0.
- Assert rst=0 mid-WAIT, asynchronously between edges -> busy=0 and mem_we=0 immediately; no ack. After release, cpu_req held -> fresh access, ack at the normal latency.
- cpu_addr changed during WAIT -> mem_addr keeps the latched value; read data comes from the original address.

Source files
------------

// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types for the CPU/debug memory arbiter: FSM state encodings and
// requester identities.
package mips_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_ACK    = 2'd3
    } arbState_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_e;

    localparam int DATA_W = 32;

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational two-way pick between the CPU and debug requesters, either
// round-robin against the last grant or with the CPU winning every tie.
module mips_arb_pick
    import mips_mem_arbiter_pkg::*;
#(
    parameter int CPU_PRIORITY = 0
) (
    input  logic   cpuReq_i,
    input  logic   dbgReq_i,
    input  owner_e lastGrant_i,
    output logic   grantValid_o,
    output owner_e grantSel_o
);

    always_comb begin
        grantValid_o = cpuReq_i | dbgReq_i;
        grantSel_o   = OWNER_CPU;
        if (cpuReq_i && dbgReq_i) begin
            // On a tie under round-robin, the port that did not win last time goes next.
            if ((CPU_PRIORITY == 0) && (lastGrant_i == OWNER_CPU)) begin
                grantSel_o = OWNER_DBG;
            end
        end else if (dbgReq_i) begin
            grantSel_o = OWNER_DBG;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port synchronous memory between the multicycle MIPS core
// and the debug/program-loader port, performing one access at a time.
module mips_mem_arbiter
    import mips_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 2,
    parameter int CPU_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    arbState_e         state_q, state_d;
    owner_e            lastGrant_q, lastGrant_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memWe_q, memWe_d;
    logic              cpuAck_q, cpuAck_d;
    logic              dbgAck_q, dbgAck_d;
    logic              cpuErr_q, cpuErr_d;
    logic              dbgErr_q, dbgErr_d;
    logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
    logic [DATA_W-1:0] dbgRdata_q, dbgRdata_d;

    logic              grantValid;
    owner_e            grantSel;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    function automatic logic inRange(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(MEM_WORDS);
    endfunction

    mips_arb_pick #(
        .CPU_PRIORITY (CPU_PRIORITY)
    ) u_pick (
        .cpuReq_i     (cpu_req),
        .dbgReq_i     (dbg_req),
        .lastGrant_i  (lastGrant_q),
        .grantValid_o (grantValid),
        .grantSel_o   (grantSel)
    );

    assign selWe    = (grantSel == OWNER_CPU) ? cpu_we    : dbg_we;
    assign selAddr  = (grantSel == OWNER_CPU) ? cpu_addr  : dbg_addr;
    assign selWdata = (grantSel == OWNER_CPU) ? cpu_wdata : dbg_wdata;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        memWe_d     = 1'b0;
        cpuAck_d    = 1'b0;
        dbgAck_d    = 1'b0;
        cpuErr_d    = 1'b0;
        dbgErr_d    = 1'b0;
        cpuRdata_d  = cpuRdata_q;
        dbgRdata_d  = dbgRdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grantValid) begin
                    owner_d     = grantSel;
                    lastGrant_d = grantSel;
                    we_d        = selWe;
                    addr_d      = selAddr;
                    wdata_d     = selWdata;
                    // The write strobe is registered so it is high for exactly the ACCESS cycle.
                    memWe_d     = selWe && inRange(selAddr);
                    state_d     = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (!inRange(addr_q)) begin
                    cpuErr_d = (owner_q == OWNER_CPU);
                    dbgErr_d = (owner_q == OWNER_DBG);
                    cpuAck_d = (owner_q == OWNER_CPU);
                    dbgAck_d = (owner_q == OWNER_DBG);
                    if (owner_q == OWNER_CPU) cpuRdata_d = '0;
                    else                      dbgRdata_d = '0;
                    state_d  = ARB_ACK;
                end else if (we_q) begin
                    cpuAck_d = (owner_q == OWNER_CPU);
                    dbgAck_d = (owner_q == OWNER_DBG);
                    state_d  = ARB_ACK;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (cnt_q == CNT_W'(READ_LATENCY)) begin
                    if (owner_q == OWNER_CPU) cpuRdata_d = mem_rdata;
                    else                      dbgRdata_d = mem_rdata;
                    cpuAck_d = (owner_q == OWNER_CPU);
                    dbgAck_d = (owner_q == OWNER_DBG);
                    state_d  = ARB_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            lastGrant_q <= OWNER_DBG;
            owner_q     <= OWNER_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            memWe_q     <= 1'b0;
            cpuAck_q    <= 1'b0;
            dbgAck_q    <= 1'b0;
            cpuErr_q    <= 1'b0;
            dbgErr_q    <= 1'b0;
            cpuRdata_q  <= '0;
            dbgRdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            memWe_q     <= memWe_d;
            cpuAck_q    <= cpuAck_d;
            dbgAck_q    <= dbgAck_d;
            cpuErr_q    <= cpuErr_d;
            dbgErr_q    <= dbgErr_d;
            cpuRdata_q  <= cpuRdata_d;
            dbgRdata_q  <= dbgRdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_we    = memWe_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = cpuAck_q;
    assign dbg_ack   = dbgAck_q;
    assign cpu_err   = cpuErr_q;
    assign dbg_err   = dbgErr_q;
    assign cpu_rdata = cpuRdata_q;
    assign dbg_rdata = dbgRdata_q;
    assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a table of single accesses plus
// hand-written arbitration, reset-abort and address-stability sequences.
module tb_mips_mem_arbiter;

    localparam int AW        = 11;
    localparam int MEM_WORDS = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpuReq, cpuWe, dbgReq, dbgWe;
    logic [AW-1:0] cpuAddr, dbgAddr;
    logic [31:0]   cpuWdata, dbgWdata;
    logic          cpuAck, dbgAck, cpuErr, dbgErr;
    logic [31:0]   cpuRdata, dbgRdata;
    logic [AW-1:0] memAddr;
    logic          memWe;
    logic [31:0]   memWdata;
    logic [31:0]   memRdata;
    logic          busy;

    logic          priCpuAck, priDbgAck, priCpuErr, priDbgErr, priMemWe, priBusy;
    logic [31:0]   priCpuRdata, priDbgRdata, priMemWdata;
    logic [AW-1:0] priMemAddr;

    int checks = 0;
    int errors = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    mips_mem_arbiter #(
        .ADDR_W(AW), .MEM_WORDS(MEM_WORDS), .READ_LATENCY(2), .CPU_PRIORITY(0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_ack(cpuAck), .cpu_rdata(cpuRdata), .cpu_err(cpuErr),
        .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
        .dbg_ack(dbgAck), .dbg_rdata(dbgRdata), .dbg_err(dbgErr),
        .mem_addr(memAddr), .mem_we(memWe), .mem_wdata(memWdata), .mem_rdata(memRdata),
        .busy(busy)
    );

    // Second instance with fixed CPU priority, fed the same requests; only its acks are observed.
    mips_mem_arbiter #(
        .ADDR_W(AW), .MEM_WORDS(MEM_WORDS), .READ_LATENCY(2), .CPU_PRIORITY(1)
    ) u_dutPri (
        .clk(clk), .rst(rst),
        .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
        .cpu_ack(priCpuAck), .cpu_rdata(priCpuRdata), .cpu_err(priCpuErr),
        .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
        .dbg_ack(priDbgAck), .dbg_rdata(priDbgRdata), .dbg_err(priDbgErr),
        .mem_addr(priMemAddr), .mem_we(priMemWe), .mem_wdata(priMemWdata), .mem_rdata(32'h0),
        .busy(priBusy)
    );

    // Memory model: synchronous write, two-cycle registered read pipeline.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] memStage;
    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
        memStage = 32'h0;
        memRdata = 32'h0;
    end
    always @(posedge clk) begin
        if (memWe) mem[memAddr] <= memWdata;
        memStage <= mem[memAddr];
        memRdata <= memStage;
    end

    typedef struct {
        bit          isDbg;
        bit          we;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
        int          expLat;
        bit          expErr;
        bit          chkRdata;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[8];

    int            resLat;
    logic [31:0]   resRdata;
    logic          resErr;
    int            resMemWe;
    int            resOtherAck;
    logic [AW-1:0] resAddr1;
    bit            resAddrHeld;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Issues one access starting in the current cycle (called just after a rising edge)
    // and follows it until ack or a 20-cycle budget. Optionally rewrites the requester's
    // address at cycle changeAt to prove the latched address is used.
    task automatic applyStimulus(input bit isDbg, input bit we, input logic [AW-1:0] addr,
                                 input logic [31:0] wdata, input int changeAt,
                                 input logic [AW-1:0] newAddr);
        logic myAck, otherAck;
        resLat      = -1;
        resRdata    = 32'h0;
        resErr      = 1'b0;
        resMemWe    = 0;
        resOtherAck = 0;
        resAddr1    = '0;
        resAddrHeld = 1'b1;
        if (isDbg) begin
            dbgReq = 1'b1; dbgWe = we; dbgAddr = addr; dbgWdata = wdata;
        end else begin
            cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWdata = wdata;
        end
        for (int k = 0; k < 20 && resLat < 0; k++) begin
            if (k == changeAt) begin
                if (isDbg) dbgAddr = newAddr;
                else       cpuAddr = newAddr;
            end
            @(negedge clk);
            if (memWe) resMemWe++;
            if (k == 1) resAddr1 = memAddr;
            if (k >= 1 && memAddr !== addr) resAddrHeld = 1'b0;
            myAck    = isDbg ? dbgAck : cpuAck;
            otherAck = isDbg ? cpuAck : dbgAck;
            if (otherAck) resOtherAck++;
            if (myAck) begin
                resLat   = k;
                resRdata = isDbg ? dbgRdata : cpuRdata;
                resErr   = isDbg ? dbgErr : cpuErr;
                if (isDbg) dbgReq = 1'b0;
                else       cpuReq = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        if (isDbg) dbgReq = 1'b0;
        else       cpuReq = 1'b0;
    endtask

    initial begin
        int rrSeq[4];
        int priSeq[4];
        int rrN, priN, bothAck;
        string nm;

        vecs[0] = '{0, 1, 11'h010, 32'hDEADBEEF, 2, 0, 0, 32'h0};
        vecs[1] = '{0, 0, 11'h010, 32'h0,        4, 0, 1, 32'hDEADBEEF};
        vecs[2] = '{1, 1, 11'h3FF, 32'h12345678, 2, 0, 0, 32'h0};
        vecs[3] = '{1, 0, 11'h3FF, 32'h0,        4, 0, 1, 32'h12345678};
        vecs[4] = '{0, 0, 11'h3FF, 32'h0,        4, 0, 1, 32'h12345678};
        vecs[5] = '{1, 0, 11'h400, 32'h0,        2, 1, 1, 32'h0};
        vecs[6] = '{0, 1, 11'h5DC, 32'hA5A5A5A5, 2, 1, 1, 32'h0};
        vecs[7] = '{0, 0, 11'h010, 32'h0,        4, 0, 1, 32'hDEADBEEF};

        rst = 1'b0;
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
        dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = '0; dbgWdata = '0;
        #2;
        checkOutput("reset_busy",     busy,     0);
        checkOutput("reset_mem_we",   memWe,    0);
        checkOutput("reset_mem_addr", memAddr,  0);
        checkOutput("reset_cpu_ack",  cpuAck,   0);
        checkOutput("reset_dbg_ack",  dbgAck,   0);
        checkOutput("reset_cpu_rdata", cpuRdata, 0);
        checkOutput("reset_dbg_err",  dbgErr,   0);

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].isDbg, vecs[i].we, vecs[i].addr, vecs[i].wdata, -1, '0);
            $sformat(nm, "vec%0d_latency", i);   checkOutput(nm, resLat, vecs[i].expLat);
            $sformat(nm, "vec%0d_err", i);       checkOutput(nm, resErr, vecs[i].expErr);
            $sformat(nm, "vec%0d_mem_we", i);
            checkOutput(nm, resMemWe, (vecs[i].we && !vecs[i].expErr) ? 1 : 0);
            $sformat(nm, "vec%0d_mem_addr", i);  checkOutput(nm, resAddr1, vecs[i].addr);
            $sformat(nm, "vec%0d_other_ack", i); checkOutput(nm, resOtherAck, 0);
            if (vecs[i].chkRdata) begin
                $sformat(nm, "vec%0d_rdata", i); checkOutput(nm, resRdata, vecs[i].expRdata);
            end
        end

        // Latched address must survive the requester changing cpu_addr during WAIT.
        applyStimulus(0, 0, 11'h3FF, 32'h0, 2, 11'h010);
        checkOutput("addrchg_latency", resLat, 4);
        checkOutput("addrchg_rdata", resRdata, 32'h12345678);
        checkOutput("addrchg_addr_held", resAddrHeld, 1);
        cpuAddr = '0;

        // Reset during the write's ACCESS cycle drops mem_we without waiting for a clock.
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 11'h030; cpuWdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        checkOutput("abortwr_we_before", memWe, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("abortwr_we_async", memWe, 0);
        checkOutput("abortwr_busy_async", busy, 0);
        cpuReq = 1'b0;
        @(negedge clk);
        checkOutput("abortwr_no_ack", cpuAck, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset during WAIT of a read, request held through and past the reset.
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 11'h010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abortrd_busy_in_wait", busy, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("abortrd_busy_async", busy, 0);
        checkOutput("abortrd_we_async", memWe, 0);
        @(negedge clk);
        checkOutput("abortrd_no_ack", cpuAck, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(0, 0, 11'h010, 32'h0, -1, '0);
        checkOutput("abortrd_fresh_latency", resLat, 4);
        checkOutput("abortrd_fresh_rdata", resRdata, 32'hDEADBEEF);

        // The aborted write must not have reached memory.
        applyStimulus(0, 0, 11'h030, 32'h0, -1, '0);
        checkOutput("abortwr_not_written", resRdata, 32'h0);

        // Both ports request continuously from reset; record the order of acks.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 11'h020; cpuWdata = 32'h11111111;
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 11'h021; dbgWdata = 32'h22222222;
        rrN = 0; priN = 0; bothAck = 0;
        for (int i = 0; i < 4; i++) begin rrSeq[i] = 9; priSeq[i] = 9; end
        for (int k = 0; k < 30 && rrN < 4; k++) begin
            @(negedge clk);
            if (cpuAck && dbgAck) bothAck++;
            if (priCpuAck && priDbgAck) bothAck++;
            if (rrN < 4 && (cpuAck || dbgAck)) begin rrSeq[rrN] = dbgAck ? 1 : 0; rrN++; end
            if (priN < 4 && (priCpuAck || priDbgAck)) begin priSeq[priN] = priDbgAck ? 1 : 0; priN++; end
            if (rrN == 4) begin cpuReq = 1'b0; dbgReq = 1'b0; end
            @(posedge clk); #1;
        end
        cpuReq = 1'b0; dbgReq = 1'b0;
        checkOutput("arb_rr_count", rrN, 4);
        checkOutput("arb_pri_count", priN, 4);
        checkOutput("arb_never_both", bothAck, 0);
        for (int i = 0; i < 4; i++) begin
            $sformat(nm, "arb_rr_order%0d", i);  checkOutput(nm, rrSeq[i], i % 2);
            $sformat(nm, "arb_pri_order%0d", i); checkOutput(nm, priSeq[i], 0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("arb_idle_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
